// File: rtl/arb_mult_pkg.sv
// Shared definitions for the multiplier arbiter: FSM encoding, default sizes
// and the product-width helper.
package arb_mult_pkg;

  localparam int ANCHO_DEF = 3;
  localparam int NREQ_DEF  = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARRANQUE = 3'd1,
    BAJADA   = 3'd2,
    ESPERA   = 3'd3,
    RESP     = 3'd4
  } estado_t;

  function automatic int ancho_prod(input int ancho);
    return 2 * ancho;
  endfunction

endpackage

// File: rtl/arbitro_multiplicador_selector.sv
// Combinational winner selection among unmasked requests. ARB_ROUND_ROBIN_EN
// selects rotating priority from a pointer; otherwise the lowest index wins.
module selector_rr
  import arb_mult_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_mask,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic [IDW-1:0]  i_ptr,
`endif
  output logic            o_hit,
  output logic [IDW-1:0]  o_winner
);

  logic [NREQ-1:0] w_cand;
  int              w_sel;

  assign w_cand = i_req & ~i_mask;
  assign o_hit  = |w_cand;

  // Scan from the weakest slot down so the strongest candidate is written last.
  always_comb begin
    w_sel = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef ARB_ROUND_ROBIN_EN
      w_sel = w_cand[(int'(i_ptr) + k) % NREQ] ? ((int'(i_ptr) + k) % NREQ) : w_sel;
`else
      w_sel = w_cand[k] ? k : w_sel;
`endif
    end
    o_winner = IDW'(w_sel);
  end

endmodule

// File: rtl/arbitro_multiplicador.sv
// Arbiter/sequencer sharing one start/fin multiplier among NREQ requesters.
// Build option: ARB_ROUND_ROBIN_EN (round-robin instead of fixed priority).
module arbitro_multiplicador
  import arb_mult_pkg::*;
#(
  parameter  int ANCHO = ANCHO_DEF,
  parameter  int NREQ  = NREQ_DEF,
  localparam int PW    = ancho_prod(ANCHO)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*ANCHO-1:0] mcando_in,
  input  logic [NREQ*ANCHO-1:0] mcador_in,
  output logic [PW-1:0]         producto_out,
  output logic [NREQ-1:0]       valid,
  output logic                  ocupado,
  output logic [ANCHO-1:0]      mul_mcando,
  output logic [ANCHO-1:0]      mul_mcador,
  output logic                  mul_start,
  input  logic [PW-1:0]         mul_producto,
  input  logic                  mul_fin
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  estado_t          r_estado, w_estado_sig;
  logic [IDW-1:0]   r_gnt_id, w_gnt_sig;
  logic             r_masked, w_masked_sig;
  logic [ANCHO-1:0] r_mcando, w_mcando_sig;
  logic [ANCHO-1:0] r_mcador, w_mcador_sig;
  logic [PW-1:0]    r_producto, w_producto_sig;
  logic [NREQ-1:0]  r_valid, w_valid_sig;
  logic             r_start, w_start_sig;
  logic             r_ocupado, w_ocupado_sig;
  logic [NREQ-1:0]  w_mask;
  logic             w_hit;
  logic [IDW-1:0]   w_winner;
`ifdef ARB_ROUND_ROBIN_EN
  logic [IDW-1:0]   r_ptr, w_ptr_sig;
`endif

  // The last-served requester sits out exactly one IDLE evaluation after RESP.
  assign w_mask = r_masked ? (NREQ'(1'b1) << r_gnt_id) : {NREQ{1'b0}};

  selector_rr #(.NREQ(NREQ)) u_sel (
    .i_req    (req),
    .i_mask   (w_mask),
`ifdef ARB_ROUND_ROBIN_EN
    .i_ptr    (r_ptr),
`endif
    .o_hit    (w_hit),
    .o_winner (w_winner)
  );

  // Next-state and next-register values; outputs are decoded from the next state
  // so they come straight out of flops.
  always_comb begin
    w_estado_sig   = r_estado;
    w_gnt_sig      = r_gnt_id;
    w_masked_sig   = r_masked;
    w_mcando_sig   = r_mcando;
    w_mcador_sig   = r_mcador;
    w_producto_sig = r_producto;
`ifdef ARB_ROUND_ROBIN_EN
    w_ptr_sig      = r_ptr;
`endif
    case (r_estado)
      IDLE: begin
        w_masked_sig = 1'b0;
        if (w_hit) begin
          w_estado_sig = ARRANQUE;
          w_gnt_sig    = w_winner;
          w_mcando_sig = mcando_in[int'(w_winner)*ANCHO +: ANCHO];
          w_mcador_sig = mcador_in[int'(w_winner)*ANCHO +: ANCHO];
`ifdef ARB_ROUND_ROBIN_EN
          w_ptr_sig    = (w_winner == IDW'(NREQ - 1)) ? {IDW{1'b0}} : (w_winner + IDW'(1'b1));
`endif
        end else begin
          w_estado_sig = IDLE;
        end
      end
      ARRANQUE: w_estado_sig = BAJADA;
      // A fin still high here belongs to an earlier operation.
      BAJADA: begin
        if (!mul_fin) begin
          w_estado_sig = ESPERA;
        end else begin
          w_estado_sig = BAJADA;
        end
      end
      ESPERA: begin
        if (mul_fin) begin
          w_estado_sig   = RESP;
          w_producto_sig = mul_producto;
        end else begin
          w_estado_sig = ESPERA;
        end
      end
      RESP: begin
        w_estado_sig = IDLE;
        w_masked_sig = 1'b1;
      end
      default: w_estado_sig = IDLE;
    endcase
    w_valid_sig   = (w_estado_sig == RESP) ? (NREQ'(1'b1) << w_gnt_sig) : {NREQ{1'b0}};
    w_start_sig   = (w_estado_sig == ARRANQUE);
    w_ocupado_sig = (w_estado_sig != IDLE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado   <= IDLE;
      r_gnt_id   <= {IDW{1'b0}};
      r_masked   <= 1'b0;
      r_mcando   <= {ANCHO{1'b0}};
      r_mcador   <= {ANCHO{1'b0}};
      r_producto <= {PW{1'b0}};
      r_valid    <= {NREQ{1'b0}};
      r_start    <= 1'b0;
      r_ocupado  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_ptr      <= {IDW{1'b0}};
`endif
    end else begin
      r_estado   <= w_estado_sig;
      r_gnt_id   <= w_gnt_sig;
      r_masked   <= w_masked_sig;
      r_mcando   <= w_mcando_sig;
      r_mcador   <= w_mcador_sig;
      r_producto <= w_producto_sig;
      r_valid    <= w_valid_sig;
      r_start    <= w_start_sig;
      r_ocupado  <= w_ocupado_sig;
`ifdef ARB_ROUND_ROBIN_EN
      r_ptr      <= w_ptr_sig;
`endif
    end
  end

  assign producto_out = r_producto;
  assign valid        = r_valid;
  assign ocupado      = r_ocupado;
  assign mul_mcando   = r_mcando;
  assign mul_mcador   = r_mcador;
  assign mul_start    = r_start;

endmodule
